scan_mux: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with a registered output and two modes.
  - Manual mode: channel chosen by `sel`.
  - Scan mode: auto round-robin over the unmasked channels, dwelling DWELL cycles on each.
- Successor to the combinational 8:1 bit mux: adds width, channel count, scan sequencing, a channel mask, and valid/wrap status.
- Sits between parallel data sources (switch banks, counters) and a single display/serial consumer.

---
 rtl/scan_mux.sv | 166 ++++++++++++++++
 tb/tb_scan_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit multiplexer with a registered output.
// Manual mode forwards the channel picked by sel; scan mode walks the
// unmasked channels round-robin, holding each one for DWELL enabled cycles.
// Status outputs report the producing channel, whether the output is a
// legitimate unmasked channel, and a one-cycle pulse when the scan wraps.
//
// Interface contract: there is no ready/valid handshake on the inputs. Every
// enabled edge samples mode/sel/mask/data_in. out_valid qualifies
// data_out/chan_out for exactly the cycle it is high and is never
// back-pressured. enable=0 freezes the data path and drops out_valid.
module scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       mask,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          chan_out,
    output logic                      out_valid,
    output logic                      wrap
);

    // Dwell counter is at least one bit wide so DWELL=1 still elaborates.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    // Operating mode as seen by the state register. Readable by bound
    // checkers as scan_mux.state.
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_e;

    state_e                state;
    state_e                req_state;

    logic [SEL_W-1:0]      ptr;
    logic [CNT_W-1:0]      cnt;

    logic [WIDTH-1:0]      chan_data [CHANNELS];

    logic [SEL_W-1:0]      cur_ptr;
    logic [CNT_W-1:0]      cur_cnt;
    logic [SEL_W-1:0]      nxt;
    logic                  nxt_found;
    logic [SEL_W-1:0]      cand;
    logic                  sel_in_range;
    logic [WIDTH-1:0]      manual_data;
    logic                  all_masked;
    logic                  ptr_masked;
    logic                  dwell_done;
    logic                  nxt_wraps;

    // Unpack the flat input bus into one word per channel.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_data[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Requested mode for this edge; a mode change acts on the next enabled edge.
    always_comb begin
        req_state = mode ? SCAN : MANUAL;
    end

    // Scan starts from channel 0 with a fresh dwell when coming out of
    // manual mode. Manual cycles already clear ptr/cnt, so this only makes
    // the restart explicit instead of relying on that invariant.
    always_comb begin
        cur_ptr = (state == SCAN) ? ptr : '0;
        cur_cnt = (state == SCAN) ? cnt : '0;
    end

    // Find the next unmasked channel after cur_ptr, wrapping round to
    // cur_ptr itself. With a single unmasked channel this returns cur_ptr.
    always_comb begin
        nxt       = cur_ptr;
        nxt_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = SEL_W'((int'(cur_ptr) + k) % CHANNELS);
            if (!nxt_found && !mask[cand]) begin
                nxt       = cand;
                nxt_found = 1'b1;
            end
        end
    end

    // Decode of the per-cycle conditions used by the update block.
    always_comb begin
        sel_in_range = (int'(sel) < CHANNELS);
        manual_data  = sel_in_range ? chan_data[sel] : '0;
        all_masked   = &mask;
        ptr_masked   = mask[cur_ptr];
        dwell_done   = (cur_cnt == CNT_LAST);
        nxt_wraps    = (nxt <= cur_ptr);
    end

    // Mode register, scan pointer/dwell counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MANUAL;
            ptr       <= '0;
            cnt       <= '0;
            data_out  <= '0;
            chan_out  <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!enable) begin
            // Freeze: data path and scan position hold, status drops.
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state <= req_state;
            case (req_state)
                MANUAL: begin
                    data_out  <= manual_data;
                    chan_out  <= sel;
                    out_valid <= sel_in_range;
                    ptr       <= '0;
                    cnt       <= '0;
                    wrap      <= 1'b0;
                end
                SCAN: begin
                    if (all_masked) begin
                        // Nothing to show: park on the current pointer.
                        ptr       <= cur_ptr;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        wrap      <= 1'b0;
                    end else if (ptr_masked) begin
                        // Current channel was masked mid-dwell: skip it
                        // immediately and spend this cycle with no output.
                        ptr       <= nxt;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        wrap      <= nxt_wraps;
                    end else begin
                        data_out  <= chan_data[cur_ptr];
                        chan_out  <= cur_ptr;
                        out_valid <= 1'b1;
                        if (dwell_done) begin
                            ptr  <= nxt;
                            cnt  <= '0;
                            wrap <= nxt_wraps;
                        end else begin
                            ptr  <= cur_ptr;
                            cnt  <= cur_cnt + 1'b1;
                            wrap <= 1'b0;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    wrap      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed test-plan steps followed by randomized traffic,
// every cycle compared against a behavioural model of the mux.
module tb_scan_mux;

    localparam int CH = 8;
    localparam int W  = 8;
    localparam int SW = 3;
    localparam int DW = 4;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [CH-1:0]   mask;
    logic [CH*W-1:0] data_in;
    logic [W-1:0]    data_out;
    logic [SW-1:0]   chan_out;
    logic            out_valid;
    logic            wrap;

    logic [W-1:0]    chans [CH];

    // Model state
    int              m_ptr;
    int              m_cnt;
    int              m_chan;
    logic [W-1:0]    m_data;
    bit              m_valid;
    bit              m_wrap;
    logic [W-1:0]    exp_q [$];

    int              checks;
    int              errors;

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    always_comb begin
        data_in = '0;
        for (int i = 0; i < CH; i++) data_in[i*W +: W] = chans[i];
    end

    scan_mux #(
        .WIDTH   (W),
        .CHANNELS(CH),
        .SEL_W   (SW),
        .DWELL   (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .sel      (sel),
        .mask     (mask),
        .data_in  (data_in),
        .data_out (data_out),
        .chan_out (chan_out),
        .out_valid(out_valid),
        .wrap     (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: one call per rising edge, using the sampled inputs.
    task automatic model_step();
        int  nxt;
        int  c;
        bit  found;
        if (reset) begin
            m_data = '0; m_chan = 0; m_valid = 0; m_wrap = 0; m_ptr = 0; m_cnt = 0;
        end else if (!enable) begin
            m_valid = 0; m_wrap = 0;
        end else if (!mode) begin
            m_data  = chans[int'(sel)];
            m_chan  = int'(sel);
            m_valid = 1;
            m_ptr   = 0; m_cnt = 0; m_wrap = 0;
        end else if (mask == {CH{1'b1}}) begin
            m_valid = 0; m_cnt = 0; m_wrap = 0;
        end else begin
            nxt = m_ptr;
            found = 0;
            for (int k = 1; k <= CH; k++) begin
                c = (m_ptr + k) % CH;
                if (!found && !mask[c]) begin
                    nxt = c;
                    found = 1;
                end
            end
            if (mask[m_ptr]) begin
                m_valid = 0;
                m_wrap  = (nxt <= m_ptr);
                m_ptr   = nxt;
                m_cnt   = 0;
            end else begin
                m_data  = chans[m_ptr];
                m_chan  = m_ptr;
                m_valid = 1;
                if (m_cnt == DW - 1) begin
                    m_wrap = (nxt <= m_ptr);
                    m_ptr  = nxt;
                    m_cnt  = 0;
                end else begin
                    m_cnt  = m_cnt + 1;
                    m_wrap = 0;
                end
            end
        end
        exp_q.push_back(m_data);
    endtask

    // Driver: apply inputs at the falling edge, check #1 after the rising edge.
    task automatic cyc(input bit rst, input bit en, input bit md,
                       input logic [SW-1:0] s, input logic [CH-1:0] m);
        @(negedge clk);
        reset = rst; enable = en; mode = md; sel = s; mask = m;
        @(posedge clk);
        model_step();
        #1;
        check("data_out", data_out, exp_q.pop_front());
        check("chan_out", chan_out, m_chan);
        check("out_valid", out_valid, m_valid);
        check("wrap", wrap, m_wrap);
    endtask

    initial begin
        int wraps;
        int valids;
        int r;
        bit rmode;
        logic [CH-1:0] rmask;

        checks = 0; errors = 0;
        m_ptr = 0; m_cnt = 0; m_chan = 0; m_data = '0; m_valid = 0; m_wrap = 0;
        reset = 1'b0; enable = 1'b0; mode = 1'b0; sel = '0; mask = '0;
        for (int i = 0; i < CH; i++) chans[i] = W'(8'hA0 + i);

        // Reset held two cycles with enable and scan requested
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        check("rst_data", data_out, 0);
        check("rst_chan", chan_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_wrap", wrap, 0);
        cyc(0, 1, 1, 0, 0);
        check("first_scan_data", data_out, 8'hA0);
        check("first_scan_chan", chan_out, 0);

        // Manual selection
        cyc(0, 1, 0, 5, 0);
        check("man5_data", data_out, 8'hA5);
        check("man5_chan", chan_out, 5);
        check("man5_valid", out_valid, 1);
        cyc(0, 1, 0, 2, 0);
        check("man2_data", data_out, 8'hA2);

        // Full scan, no mask: 4 cycles per channel, one wrap in 40 cycles
        wraps = 0; valids = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 1, 0, 0);
            check("scan_order", chan_out, (i / DW) % CH);
            if (wrap) wraps++;
            if (out_valid) valids++;
        end
        check("scan_wrap_count", wraps, 1);
        check("scan_valid_count", valids, 40);

        // Mask 0000_0110, then mask channel 3 during its second dwell cycle
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 8'b0000_0110);
        cyc(0, 1, 1, 0, 8'b0000_0110);
        check("skip_to_3", chan_out, 3);
        cyc(0, 1, 1, 0, 8'b0000_0110);
        cyc(0, 1, 1, 0, 8'b0000_1110);
        check("masked_mid_valid", out_valid, 0);
        cyc(0, 1, 1, 0, 8'b0000_1110);
        check("after_mask_data", data_out, 8'hA4);
        check("after_mask_chan", chan_out, 4);

        // All masked, resume, then freeze
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 8'hFF);
            check("allmask_hold", data_out, 8'hA4);
        end
        cyc(0, 1, 1, 0, 0);
        check("resume_chan", chan_out, 4);
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("freeze_data", data_out, 8'hA4);
        end
        cyc(0, 1, 1, 0, 0);
        check("unfreeze_chan", chan_out, 4);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check("advance_chan", chan_out, 5);

        // Mode switch mid-dwell on channel 3
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) cyc(0, 1, 1, 0, 0);
        check("on_chan3", chan_out, 3);
        cyc(0, 1, 0, 6, 0);
        check("switch_man_data", data_out, 8'hA6);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 0, 0);
            check("restart_chan0", chan_out, 0);
        end
        cyc(0, 1, 1, 0, 0);
        check("restart_next", chan_out, 1);

        // Randomized traffic against the model
        rmode = 1'b1;
        rmask = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0)
                for (int j = 0; j < CH; j++) chans[j] = W'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                4, 5:    rmask = '0;
                6:       rmask = '1;
                7:       rmask = ~(CH'(1) << $urandom_range(0, CH - 1));
                8, 9:    rmask = CH'($urandom);
                default: rmask = rmask;
            endcase
            if ($urandom_range(0, 9) == 0) rmode = ~rmode;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rmode,
                SW'($urandom_range(0, CH - 1)), rmask);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
